// File: rtl/alu_pkg.sv
// Opcode map, engine state encoding and opcode classification for alu_muldiv.
package alu_pkg;

    // Single-cycle ops
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    // Multi-cycle ops and HI/LO reads
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

    // True for opcodes that run on the iterative engine
    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with architectural HI/LO.
// One shift-add (multiply) or restoring subtract-shift (divide) per RUN cycle,
// on operand magnitudes; signs are fixed up in the single FIX cycle.
// Define ALU_DIV_EN to build the divide datapath; without it only MULT/MULTU start.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    // opnd: multiplicand (mul) or divisor (div) magnitude
    // p_hi/p_lo: product accumulator/multiplier (mul) or remainder/quotient (div)
    logic [WIDTH-1:0]   opnd, p_hi, p_lo;
    logic               neg_p;          // negate product or quotient
    logic               signed_op, can_start, start;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_neg;
`ifdef ALU_DIV_EN
    logic               is_div;
    logic               neg_r;          // remainder follows the dividend sign
    logic               div0;
    logic [WIDTH:0]     div_sh;
`endif

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

`ifdef ALU_DIV_EN
    assign can_start = is_multi(op);
`else
    assign can_start = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign start = valid && !busy && can_start;

    // One iteration step of the active operation
    always_comb begin
        mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
        nxt_hi  = mul_sum[WIDTH:1];
        nxt_lo  = {mul_sum[0], p_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_sh  = {p_hi, p_lo[WIDTH-1]};
        if (is_div) begin
            if (div_sh >= {1'b0, opnd}) begin
                nxt_hi = WIDTH'(div_sh - {1'b0, opnd});
                nxt_lo = {p_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_sh[WIDTH-1:0];
                nxt_lo = {p_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient
    always_comb begin
        prod_neg = -{p_hi, p_lo};
        fix_hi   = neg_p ? prod_neg[2*WIDTH-1:WIDTH] : p_hi;
        fix_lo   = neg_p ? prod_neg[WIDTH-1:0]       : p_lo;
`ifdef ALU_DIV_EN
        if (is_div) begin
            fix_hi = neg_r ? -p_hi : p_hi;
            fix_lo = div0 ? '1 : (neg_p ? -p_lo : p_lo);
        end
`endif
    end

    // Engine FSM: IDLE -> RUN (WIDTH steps) -> FIX (HI/LO write) -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    p_hi  <= '0;
                    opnd  <= a_mag;
                    p_lo  <= b_mag;
                    neg_p <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DIV_EN
                    is_div <= (op == OP_DIV) || (op == OP_DIVU);
                    neg_r  <= signed_op && a[WIDTH-1];
                    div0   <= (b == '0);
                    if ((op == OP_DIV) || (op == OP_DIVU)) begin
                        opnd <= b_mag;
                        p_lo <= a_mag;
                    end
`endif
                end
                RUN: begin
                    p_hi <= nxt_hi;
                    p_lo <= nxt_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops plus HI/LO reads from the
// iterative multiply/divide engine. Define ALU_DIV_EN to enable DIV/DIVU.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alucont,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic             valid,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] hi, lo;

    muldiv_unit #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .reset (reset),
        .op    (alucont),
        .a     (rd1),
        .b     (rd2),
        .valid (valid),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    // Result mux; multi-cycle and unlisted opcodes read as zero
    always_comb begin
        res = '0;
        case (alucont)
            OP_AND:  res = rd1 & rd2;
            OP_OR:   res = rd1 | rd2;
            OP_ADD:  res = rd1 + rd2;
            OP_SUB:  res = rd1 - rd2;
            OP_SLTU: res = WIDTH'(rd1 < rd2);
            OP_SLT:  res = WIDTH'($signed(rd1) < $signed(rd2));
            OP_NOR:  res = ~(rd1 | rd2);
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor to the single-cycle MIPS ALU: a WIDTH-bit integer ALU that executes the single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) combinationally and adds an iterative multiply/divide engine with architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO). It sits in the execute stage. The controller starts a multi-cycle op with `valid` and stalls on `busy` until `done`.

## Interface
- `WIDTH`, default 32: operand, result, HI and LO width (≥ 4).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `alucont` input 4: operation select.
- `rd1` input WIDTH: operand A (multiplicand / dividend).
- `rd2` input WIDTH: operand B (multiplier / divisor).
- `valid` input 1: start request for MULT/MULTU/DIV/DIVU; ignored for other ops.
- `res` output WIDTH: combinational result.
- `zero` output 1: high when `res` is all zeros.
- `busy` output 1: engine occupied.
- `done` output 1: one-cycle pulse; HI/LO are written at the end of this cycle.

## Operation
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, SLTU 0011, SUB 0110, SLT 0111 (signed), NOR 1100.
  - MULT 1000, MULTU 1001, DIV 1010, DIVU 1011, MFHI 1101, MFLO 1110.
  - Unlisted codes: `res` = 0.
- Single-cycle ops:
  - `res` is purely combinational from `alucont`/`rd1`/`rd2`, valid in the same cycle.
  - ADD/SUB wrap modulo 2^WIDTH. No carry or overflow output.
  - SLT/SLTU return 1 or 0, zero-extended.
- MFHI/MFLO: `res` = current HI/LO register value, combinational.
- Multi-cycle ops drive `res` = 0.
- Accept: at a rising edge, if `valid` && !`busy` && `alucont` ∈ {MULT, MULTU, DIV, DIVU}:
  - Latch the operands and the op.
  - For signed ops, latch operand magnitudes plus the result sign flags.
- FSM states:
  - IDLE → RUN on accept.
  - RUN iterates exactly WIDTH cycles, counter counting 0..WIDTH-1. One shift-add (multiply) or one restoring subtract-shift (divide) per cycle.
  - RUN → FIX when the counter reaches WIDTH-1.
  - FIX (1 cycle): apply sign correction, assert `done`, write HI/LO at the end of the cycle, then → IDLE.
- Results:
  - Multiply: {HI, LO} = full 2·WIDTH-bit product.
  - Divide: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: completes with normal latency; LO = all ones, HI = `rd1` as latched.
- Signed MIN / −1: LO = MIN, HI = 0.
- `valid` while `busy`: ignored, no queueing. Single-cycle ops still evaluate normally.
- MFHI/MFLO while `busy`: return the old HI/LO. The controller must stall.
- `reset` at any time (including mid-RUN or in FIX):
  - Next state IDLE, counter 0, HI = LO = 0.
  - `busy` = 0, `done` = 0. No HI/LO write occurs.

## Timing
- Reset values: `busy` 0, `done` 0, HI 0, LO 0. After reset, `res` for MFHI/MFLO = 0. `res`/`zero` are otherwise combinational from the inputs.
- Accept at edge E0:
  - `busy` is high from E0 until edge E0+WIDTH+1.
  - `done` is high in the cycle between E0+WIDTH and E0+WIDTH+1.
  - New HI/LO are visible to MFHI/MFLO from E0+WIDTH+1.
  - Total latency: WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: a new `valid` is accepted at E0+WIDTH+1 at the earliest.
- `busy` and `done` are registered (state-decoded). There is no combinational path from `valid` to `busy`.

## Configuration
- `ALU_DIV_EN` defined: DIV/DIVU are implemented as described.
- `ALU_DIV_EN` undefined:
  - Divide datapath is omitted.
  - DIV/DIVU are never accepted: `busy` stays 0 and HI/LO are unchanged.
  - `res` = 0 for those codes.
  - MULT/MULTU are unaffected.

## Structure
- Package `alu_pkg`:
  - 4-bit opcode localparams/enum (all codes above).
  - FSM state enum {IDLE, RUN, FIX}.
  - Helper to classify an opcode as multi-cycle.
- Sub-module `muldiv_unit`:
  - Holds the FSM, counter, operand/partial registers, sign correction and HI/LO.
  - Exports `hi`, `lo`, `busy`, `done`.
- Top `alu_muldiv`: combinational op mux plus instance of `muldiv_unit`.

## Test plan
- WIDTH=32:
  - ADD 0xFFFFFFFF+1 → `res` 0, `zero` 1.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU same operands → 0.
  - NOR 0,0 → 0xFFFFFFFF.
- MULT −3 × 7 with `valid`:
  - `busy` high for 33 cycles; `done` pulse in the 33rd cycle.
  - Then MFHI = 0xFFFFFFFF, MFLO = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI 0xFFFFFFFE, LO 0x00000001.
- Division cases:
  - DIV −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF.
  - DIVU 100 / 0 → LO 0xFFFFFFFF, HI 100.
  - DIV 0x80000000 / −1 → LO 0x80000000, HI 0.
- Second `valid` (MULT 2×2) during a busy MULT 5×5:
  - Ignored; final LO = 25.
  - MFLO before `done` returns the previous LO.
- `reset` asserted in RUN cycle 10:
  - Next cycle `busy` 0, `done` never pulses, MFHI = MFLO = 0.
  - Rebuild without `ALU_DIV_EN`: DIV `valid` → `busy` stays 0, HI/LO unchanged.
